and_gate: RTL and testbench
===========================

Name: and_gate

Overview:
- Clocked, registered bitwise AND of two operand vectors, with valid tracking and simple status outputs.
- Used as a basic combining/qualifying stage: two enable/condition vectors in, registered AND result out after a fixed pipeline latency.
- Also provides all-bits-set and any-bit-set flags, plus a saturating counter of 0->1 transitions of the all-set flag for debug observation.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).
- PIPE_STAGES, 1, number of register stages from inputs to out (legal range 1..8); latency equals PIPE_STAGES cycles.
- CNT_WIDTH, 16, width of rise_count.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b in the current cycle.
- clr_count  input  1  synchronous clear of rise_count.
- out  output  WIDTH  registered result a & b.
- out_valid  output  1  high for one cycle per accepted input, PIPE_STAGES cycles after acceptance.
- out_all  output  1  reduction AND of out (1 when every bit of out is 1).
- out_any  output  1  reduction OR of out.
- rise_count  output  CNT_WIDTH  saturating count of out_all 0->1 transitions.

Behaviour:
- Reset (rst=1 at a rising clk edge): every pipeline data register, out, and rise_count clear to 0; every valid bit and out_valid clear to 0. out_all and out_any therefore read 0. Reset overrides all other inputs in the same cycle.
- Reset mid-operation: in-flight results are discarded; no out_valid is produced for inputs accepted before reset.
- Stage 1 captures a & b when in_valid=1. Each later stage k captures stage k-1 data when stage k-1 valid=1.
- Valid bits shift one stage per cycle unconditionally.
- A stage's data holds its previous value when its incoming valid is 0. out therefore holds the last valid result indefinitely.
- out is the final stage's data; out_valid is the final stage's valid.
- Latency: inputs accepted at edge N appear on out/out_valid after edge N+PIPE_STAGES-1 (visible through cycle N+PIPE_STAGES).
- Throughput: one accepted input per cycle. No backpressure; no input is dropped.
- in_valid=0: no state change in stage-1 data; a zero valid bubble enters the pipe.
- out_all and out_any are combinational functions of the registered out. With WIDTH=1, out_all = out_any = out.
- rise_count maintenance:
  - Track prev_all, the out_all value of the previous valid result (reset 0).
  - When out_valid=1 and out_all=1 and prev_all=0, increment rise_count.
  - When out_valid=1, update prev_all to out_all.
  - rise_count saturates at all-ones and never wraps.
  - clr_count=1 clears rise_count to 0 at the edge. Clear wins over a simultaneous increment, but prev_all still updates normally.
- X-free: all registers have defined reset values. No latches.

Test Plan:
- Reset: assert rst for 2 cycles with a=1, b=1, in_valid=1 -> out=0, out_valid=0, out_all=0, out_any=0, rise_count=0 throughout reset.
- Truth table, WIDTH=1, PIPE_STAGES=1:
  - Stimulus: in_valid=1 each cycle with (a,b) = 00,10,11,01,00,10,10,01.
  - Required: out one cycle later = 0,0,1,0,0,0,0,0; out_valid=1 each of those cycles; rise_count ends at 1.
- Hold behaviour: apply a=1, b=1, in_valid=1 for one cycle, then a=0, b=0, in_valid=0 for 5 cycles -> out stays 1, and out_valid pulses exactly once.
- Latency and width, WIDTH=8, PIPE_STAGES=3: a=0xF0, b=0x3C at cycle 0 -> out=0x30 and out_valid=1 exactly 3 cycles later; out_any=1, out_all=0. Next, a=0xFF, b=0xFF -> out=0xFF, out_all=1, rise_count increments to 1.
- Counter clear and priority: drive a 0->1 transition of out_all with clr_count=1 on the same edge -> rise_count=0. The next 0->1 transition -> rise_count=1.
- Saturation (CNT_WIDTH=2): produce 5 out_all rises -> rise_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/and_gate.sv
// Registered bitwise AND with a PIPE_STAGES-deep valid-tracked pipeline,
// all/any status flags and a saturating counter of all-set rises.
module and_gate #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  input  logic                 clr_count,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic                 out_all,
  output logic                 out_any,
  output logic [CNT_WIDTH-1:0] rise_count
);

  logic [WIDTH-1:0]     data_reg  [PIPE_STAGES];
  logic                 valid_reg [PIPE_STAGES];
  logic                 prev_all_reg;
  logic                 prev_all_next;
  logic [CNT_WIDTH-1:0] rise_count_reg;
  logic [CNT_WIDTH-1:0] rise_count_next;

  // Each stage loads only when its incoming valid is set, so data holds
  // through bubbles; valid bits shift unconditionally.
  generate
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            data_reg[0]  <= '0;
            valid_reg[0] <= 1'b0;
          end else begin
            valid_reg[0] <= in_valid;
            if (in_valid) begin
              data_reg[0] <= a & b;
            end
          end
        end
      end else begin : g_later
        always_ff @(posedge clk) begin
          if (rst) begin
            data_reg[gi]  <= '0;
            valid_reg[gi] <= 1'b0;
          end else begin
            valid_reg[gi] <= valid_reg[gi-1];
            if (valid_reg[gi-1]) begin
              data_reg[gi] <= data_reg[gi-1];
            end
          end
        end
      end
    end
  endgenerate

  assign out       = data_reg[PIPE_STAGES-1];
  assign out_valid = valid_reg[PIPE_STAGES-1];
  assign out_all   = &out;
  assign out_any   = |out;

  // prev_all follows valid results only; clear beats a same-edge increment.
  always_comb begin
    prev_all_next   = prev_all_reg;
    rise_count_next = rise_count_reg;
    if (out_valid) begin
      prev_all_next = out_all;
      if (out_all && !prev_all_reg && (rise_count_reg != {CNT_WIDTH{1'b1}})) begin
        rise_count_next = rise_count_reg + 1'b1;
      end
    end
    if (clr_count) begin
      rise_count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_all_reg   <= 1'b0;
      rise_count_reg <= '0;
    end else begin
      prev_all_reg   <= prev_all_next;
      rise_count_reg <= rise_count_next;
    end
  end

  assign rise_count = rise_count_reg;

endmodule

// File: tb/tb_and_gate.sv
// Drives three and_gate configurations from shared stimulus and checks each
// against a history-based model of the accepted-input stream.
module tb_and_gate;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       in_valid;
  logic       clr_count;

  logic [0:0] out_w1;  logic v_w1, all_w1, any_w1;  logic [15:0] rc_w1;
  logic [7:0] out_w8;  logic v_w8, all_w8, any_w8;  logic [15:0] rc_w8;
  logic [3:0] out_s;   logic v_s,  all_s,  any_s;   logic [1:0]  rc_s;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1), .PIPE_STAGES(1), .CNT_WIDTH(16)) u_w1 (
    .clk(clk), .rst(rst), .a(a8[0:0]), .b(b8[0:0]), .in_valid(in_valid),
    .clr_count(clr_count), .out(out_w1), .out_valid(v_w1), .out_all(all_w1),
    .out_any(any_w1), .rise_count(rc_w1));

  and_gate #(.WIDTH(8), .PIPE_STAGES(3), .CNT_WIDTH(16)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
    .clr_count(clr_count), .out(out_w8), .out_valid(v_w8), .out_all(all_w8),
    .out_any(any_w8), .rise_count(rc_w8));

  and_gate #(.WIDTH(4), .PIPE_STAGES(2), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .a(a8[3:0]), .b(b8[3:0]), .in_valid(in_valid),
    .clr_count(clr_count), .out(out_s), .out_valid(v_s), .out_all(all_s),
    .out_any(any_s), .rise_count(rc_s));

  // Model state: per-edge record of accepted inputs plus per-DUT counters.
  int         pst  [3] = '{1, 3, 2};
  logic [7:0] msk  [3] = '{8'h01, 8'hFF, 8'h0F};
  int         cmax [3] = '{65535, 65535, 3};
  logic       acc_v [MAXC];
  logic [7:0] acc_d [MAXC];
  int         last_rst = -1;
  int         cyc = 0;
  logic [7:0] e_out [3];
  logic       e_val [3];
  int         e_cnt [3];
  logic       e_prev [3];

  int errors = 0;
  int checks = 0;

  function automatic logic exp_valid(int d, int t);
    int n;
    n = t - pst[d] + 1;
    if (n < 0 || n <= last_rst) return 1'b0;
    return acc_v[n];
  endfunction

  function automatic logic [7:0] exp_out(int d, int t);
    for (int n = t - pst[d] + 1; n > last_rst && n >= 0; n--) begin
      if (acc_v[n]) return acc_d[n] & msk[d];
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] o, input logic v,
                           input logic al, input logic an, input int rc);
    string p;
    p = $sformatf("dut%0d", d);
    chk({p, ".out"}, {24'h0, o}, {24'h0, e_out[d]});
    chk({p, ".out_valid"}, {31'h0, v}, {31'h0, e_val[d]});
    chk({p, ".out_all"}, {31'h0, al}, {31'h0, (e_out[d] == msk[d])});
    chk({p, ".out_any"}, {31'h0, an}, {31'h0, (e_out[d] != 8'h00)});
    chk({p, ".rise_count"}, rc, e_cnt[d]);
  endtask

  // One clock: drive inputs, take the edge, advance the model, then sample.
  task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic iv,
                      input logic cl, input logic rs);
    logic all_q;
    a8 = av; b8 = bv; in_valid = iv; clr_count = cl; rst = rs;
    @(posedge clk);
    acc_v[cyc] = iv && !rs;
    acc_d[cyc] = av & bv;
    for (int d = 0; d < 3; d++) begin
      all_q = (e_out[d] == msk[d]);
      if (rs) begin
        e_cnt[d]  = 0;
        e_prev[d] = 1'b0;
      end else begin
        if (e_val[d]) begin
          if (all_q && !e_prev[d] && e_cnt[d] < cmax[d]) e_cnt[d]++;
          e_prev[d] = all_q;
        end
        if (cl) e_cnt[d] = 0;
      end
    end
    if (rs) last_rst = cyc;
    for (int d = 0; d < 3; d++) begin
      e_val[d] = exp_valid(d, cyc);
      e_out[d] = exp_out(d, cyc);
    end
    #1;
    check_dut(0, {7'h0, out_w1}, v_w1, all_w1, any_w1, {16'h0, rc_w1});
    check_dut(1, out_w8, v_w8, all_w8, any_w8, {16'h0, rc_w8});
    check_dut(2, {4'h0, out_s}, v_s, all_s, any_s, {30'h0, rc_s});
    $display("cyc=%0d a=%02h b=%02h v=%0b clr=%0b rst=%0b | w1 %0h/%0b/%0d w8 %02h/%0b/%0d s %0h/%0b/%0d",
             cyc, av, bv, iv, cl, rs, out_w1, v_w1, rc_w1, out_w8, v_w8, rc_w8, out_s, v_s, rc_s);
    cyc++;
  endtask

  logic [1:0] tt [8];
  logic [7:0] ra, rb;

  initial begin
    for (int d = 0; d < 3; d++) begin
      e_out[d] = 8'h00; e_val[d] = 1'b0; e_cnt[d] = 0; e_prev[d] = 1'b0;
    end
    a8 = 8'h00; b8 = 8'h00; in_valid = 1'b0; clr_count = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset held two cycles with all-ones operands presented.
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("reset.out_w8", {24'h0, out_w8}, 32'h0);

    // Truth table (a,b) per bit, replicated across the wider DUTs.
    tt = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 8; i++) begin
      step(tt[i][1] ? 8'hFF : 8'h00, tt[i][0] ? 8'hFF : 8'h00, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("truth.rise_w1", {16'h0, rc_w1}, 32'd1);

    // Hold: one all-ones result, then five bubbles.
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("hold.out_w1", {31'h0, out_w1}, 32'd1);

    // Latency/width on the 3-stage instance.
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    step(8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("lat.out_w8", {24'h0, out_w8}, 32'h30);
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("lat.rise_w8", {16'h0, rc_w8}, 32'd1);

    // Clear on the rising edge of the 1-stage instance, then a fresh rise.
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr.rise_w1", {16'h0, rc_w1}, 32'd0);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("clr.rise_w1_again", {16'h0, rc_w1}, 32'd1);

    // Saturation on the 2-bit counter: five rises.
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("sat.rise_s", {30'h0, rc_s}, 32'd3);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) begin
        ra = 8'hFF; rb = 8'hFF;
      end else begin
        ra = 8'($urandom); rb = 8'($urandom);
      end
      step(ra, rb, 1'($urandom_range(3) != 0), ($urandom_range(15) == 0),
           ($urandom_range(63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
